// File: rtl/sram_responder_if.sv
// sram_responder_if: 16-bit core-to-memory bus between the core's memory interface and the RAM.
interface sram_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
);
  logic              to_mem_mem_enable;
  logic              to_mem_read_enable;
  logic              to_mem_write_enable;
  logic [ADDR_W-1:0] to_mem_address;
  logic [DATA_W-1:0] to_mem_data;
  logic [DATA_W-1:0] from_mem_data;
  logic              rd_valid;
  modport master (
    output to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable, to_mem_address, to_mem_data,
    input  from_mem_data, rd_valid
  );
  modport slave (
    input  to_mem_mem_enable, to_mem_read_enable, to_mem_write_enable, to_mem_address, to_mem_data,
    output from_mem_data, rd_valid
  );
endinterface

// File: rtl/sram_responder.sv
// sram_responder: word-addressed RAM with fixed read latency, backdoor preload port and bus error tracking.
module sram_responder #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  sram_responder_if.slave   bus,
  input  logic              bd_write,
  input  logic [ADDR_W-1:0] bd_address,
  input  logic [DATA_W-1:0] bd_data,
  output logic              protocol_error,
  output logic [15:0]       access_count
);
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("sram_responder: READ_LATENCY must be in 1..4");
  end
  logic                             rd, wr, err;
  logic [READ_LATENCY-1:0]          vld;
  logic [READ_LATENCY*ADDR_W-1:0]   adr;
  logic [DATA_W-1:0]                mem [2**ADDR_W];
  always_comb begin
    rd  = bus.to_mem_mem_enable & bus.to_mem_read_enable & ~bus.to_mem_write_enable;
    wr  = bus.to_mem_mem_enable & bus.to_mem_write_enable & ~bus.to_mem_read_enable;
    err = bus.to_mem_mem_enable & bus.to_mem_read_enable & bus.to_mem_write_enable;
  end
  // Bus write is issued last so it overrides a backdoor write to the same word.
  always_ff @(posedge clock) begin
    if (bd_write) mem[bd_address] <= bd_data;
    if (wr) mem[bus.to_mem_address] <= bus.to_mem_data;
  end
  always_ff @(posedge clock)
    adr <= (READ_LATENCY*ADDR_W)'({adr, bus.to_mem_address});
  // The array is read only at the last stage, so writes landing while a read is in flight are seen.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      vld               <= '0;
      bus.rd_valid      <= 1'b0;
      bus.from_mem_data <= '0;
      protocol_error    <= 1'b0;
      access_count      <= '0;
    end else begin
      vld          <= READ_LATENCY'({vld, rd});
      bus.rd_valid <= vld[READ_LATENCY-1];
      if (vld[READ_LATENCY-1]) bus.from_mem_data <= mem[adr[READ_LATENCY*ADDR_W-1 -: ADDR_W]];
      if (err) protocol_error <= 1'b1;
      if ((rd || wr) && access_count != 16'hFFFF) access_count <= access_count + 16'd1;
    end
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: random and directed traffic against a queue-based memory model with a decoupled monitor.
module tb_sram_responder;
  localparam int LAT = 3;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bd_write;
  logic [11:0] bd_address;
  logic [15:0] bd_data;
  logic        protocol_error;
  logic [15:0] access_count;
  always #5 clock = ~clock;
  sram_responder_if #(.ADDR_W(12), .DATA_W(16)) bus ();
  sram_responder #(.ADDR_W(12), .DATA_W(16), .READ_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .bd_write(bd_write), .bd_address(bd_address), .bd_data(bd_data),
    .protocol_error(protocol_error), .access_count(access_count)
  );
  typedef struct { int addr; int due; } rd_t;
  logic [15:0] ref_mem [4096];
  rd_t         pend[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_data = '0;
  int          cyc = 0, exp_cnt = 0, n_chk = 0, n_fail = 0;
  bit          exp_err = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference model: a read returns the array contents as of the edge it completes on, before that edge's writes.
  initial forever begin
    bit rd, wr, er;
    @(posedge clock);
    cyc++;
    rd = bus.to_mem_mem_enable && bus.to_mem_read_enable && !bus.to_mem_write_enable;
    wr = bus.to_mem_mem_enable && bus.to_mem_write_enable && !bus.to_mem_read_enable;
    er = bus.to_mem_mem_enable && bus.to_mem_read_enable && bus.to_mem_write_enable;
    if (reset && pend.size() > 0 && pend[0].due == cyc) begin
      exp_q.push_back(ref_mem[pend[0].addr]);
      void'(pend.pop_front());
    end
    if (bd_write) ref_mem[bd_address] = bd_data;
    if (reset) begin
      if (rd) pend.push_back('{addr: int'(bus.to_mem_address), due: cyc + LAT});
      if (wr) ref_mem[bus.to_mem_address] = bus.to_mem_data;
      if (er) exp_err = 1;
      if ((rd || wr) && exp_cnt < 65535) exp_cnt++;
    end
  end
  initial forever begin
    bit ev;
    @(posedge clock);
    #1;
    ev = exp_q.size() != 0;
    check("rd_valid", bus.rd_valid, ev);
    if (ev) last_data = exp_q.pop_front();
    check("from_mem_data", bus.from_mem_data, last_data);
    check("protocol_error", protocol_error, exp_err);
    check("access_count", access_count, exp_cnt);
  end
  task automatic drive(input bit me, input bit re, input bit we, input logic [11:0] a, input logic [15:0] d,
                       input bit bw = 0, input logic [11:0] ba = 0, input logic [15:0] bdd = 0);
    @(negedge clock);
    bus.to_mem_mem_enable   = me;
    bus.to_mem_read_enable  = re;
    bus.to_mem_write_enable = we;
    bus.to_mem_address      = a;
    bus.to_mem_data         = d;
    bd_write   = bw;
    bd_address = ba;
    bd_data    = bdd;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 12'h0, 16'h0);
  endtask
  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b0;
    bus.to_mem_mem_enable = 0; bus.to_mem_read_enable = 0; bus.to_mem_write_enable = 0;
    bd_write = 0;
    pend.delete();
    exp_q.delete();
    exp_cnt = 0;
    exp_err = 0;
    last_data = '0;
    repeat (n) @(negedge clock);
    reset = 1'b1;
  endtask
  initial begin
    bus.to_mem_mem_enable = 0; bus.to_mem_read_enable = 0; bus.to_mem_write_enable = 0;
    bus.to_mem_address = '0; bus.to_mem_data = '0;
    bd_write = 0; bd_address = '0; bd_data = '0;
    do_reset(3);
    drive(1, 0, 1, 12'h010, 16'hBEEF);
    drive(1, 1, 0, 12'h010, 16'h0);
    idle(LAT + 2);
    // Reset lands while two reads are still in flight.
    drive(0, 0, 0, 12'h0, 16'h0, 1, 12'h040, 16'h4444);
    drive(1, 1, 0, 12'h040, 16'h0);
    drive(1, 1, 0, 12'h010, 16'h0);
    do_reset(2);
    idle(LAT + 3);
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 12'h0, 16'h0, 1, 12'(i), 16'(i) ^ 16'h5A5A);
    for (int i = 0; i < 8; i++) drive(1, 1, 0, 12'(i), 16'h0);
    idle(LAT + 2);
    drive(0, 0, 0, 12'h0, 16'h0, 1, 12'h020, 16'h1111);
    drive(1, 1, 0, 12'h020, 16'h0);
    drive(1, 0, 1, 12'h020, 16'h2222);
    idle(LAT + 2);
    drive(1, 0, 1, 12'h050, 16'hAAAA, 1, 12'h050, 16'hBBBB);
    drive(1, 0, 1, 12'h051, 16'hCCCC, 1, 12'h052, 16'hDDDD);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 12'h050 + 12'(i), 16'h0);
    idle(LAT + 2);
    drive(0, 0, 0, 12'h0, 16'h0, 1, 12'h030, 16'h3333);
    drive(1, 1, 1, 12'h030, 16'hFFFF);
    drive(1, 1, 0, 12'h030, 16'h0);
    idle(LAT + 2);
    repeat (4) drive(0, 1, 0, 12'h010, 16'h0);
    repeat (2) drive(0, 0, 1, 12'h010, 16'h1234);
    idle(LAT + 2);
    for (int i = 0; i < 16; i++) drive(0, 0, 0, 12'h0, 16'h0, 1, 12'(i), 16'($urandom));
    repeat (400) drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       12'($urandom_range(0, 15)), 16'($urandom),
                       $urandom_range(0, 4) == 0, 12'($urandom_range(0, 15)), 16'($urandom));
    idle(LAT + 2);
    repeat (65540) drive(1, 1, 0, 12'($urandom_range(0, 15)), 16'h0);
    idle(LAT + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
